// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow valid/ready beats into one wide word.
// Optional packet-end support (last_i/last_o, early close) under `STREAM_UPSIZER_LAST_EN.
module stream_upsizer #(
   parameter  int IN_WIDTH  = 8,
   parameter  int RATIO     = 4,
   localparam int OUT_WIDTH = IN_WIDTH * RATIO,
   localparam int CNT_WIDTH = $clog2(RATIO + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [IN_WIDTH-1:0]  data_i,
`ifdef STREAM_UPSIZER_LAST_EN
   input  logic                 last_i,
   output logic                 last_o,
`endif
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [OUT_WIDTH-1:0] data_o,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   typedef enum logic {FILL, FULL} state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(RATIO - 1);

   state_t                 state;
   logic [CNT_WIDTH-1:0]   idx;
   logic                   out_hs;
   logic                   accept;
   logic                   closing;
   logic                   last_beat;
   logic [OUT_WIDTH-1:0]   word_nxt;

`ifdef STREAM_UPSIZER_LAST_EN
   assign last_beat = last_i;
`else
   assign last_beat = 1'b0;
`endif

   assign valid_o = (state == FULL);
   assign ready_o = (!valid_o || ready_i) && !flush_i;
   assign out_hs  = valid_o && ready_i;
   assign accept  = valid_i && ready_o;
   assign closing = accept && ((idx == LAST_IDX) || last_beat);

   // A word leaving this cycle is replaced by a zeroed one so unwritten lanes read as zero.
   always_comb begin
      word_nxt = out_hs ? '0 : data_o;
      if (accept) begin
         word_nxt[int'(idx)*IN_WIDTH +: IN_WIDTH] = data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= FILL;
         idx    <= '0;
         data_o <= '0;
         cnt_o  <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
         last_o <= 1'b0;
`endif
      end else if (flush_i) begin
         state  <= FILL;
         idx    <= '0;
         data_o <= '0;
         cnt_o  <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
         last_o <= 1'b0;
`endif
      end else begin
         data_o <= word_nxt;
         if (out_hs) begin
            state <= FILL;
            cnt_o <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
            last_o <= 1'b0;
`endif
         end
         // In FULL a beat is only accepted alongside the handshake, when idx is already 0.
         if (accept) begin
            if (closing) begin
               state <= FULL;
               cnt_o <= idx + 1'b1;
               idx   <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
               last_o <= last_i;
`endif
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - scoreboard bench for stream_upsizer (IN_WIDTH=8, RATIO=4).
// Exercises the packet-end path when STREAM_UPSIZER_LAST_EN is defined.
module tb_stream_upsizer;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [7:0]  data_i = '0;
   logic        last_i = 1'b0;
   logic        last_o;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] data_o;
   logic [2:0]  cnt_o;

   int vectors = 0;
   int miscompares = 0;
   int stalls = 0;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  c;
      logic        l;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_word = '0;
   int          m_idx = 0;

   stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
`ifdef STREAM_UPSIZER_LAST_EN
      .last_i  (last_i),
      .last_o  (last_o),
`endif
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .cnt_o   (cnt_o)
   );

`ifndef STREAM_UPSIZER_LAST_EN
   assign last_o = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_word = '0;
      m_idx  = 0;
   endtask

   // Drive one beat and hold it until accepted; called at posedge+1, returns at posedge+1.
   task automatic send(input logic [7:0] d, input logic l);
      int   wait_cycles;
      exp_t e;
      valid_i = 1'b1;
      data_i  = d;
      last_i  = l;
      wait_cycles = 0;
      @(negedge clk_i);
      while (!ready_o && wait_cycles < 20) begin
         stalls++;
         wait_cycles++;
         @(negedge clk_i);
      end
      if (!ready_o) check("send_timeout", 64'(ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      m_word[m_idx*8 +: 8] = d;
      m_idx++;
`ifdef STREAM_UPSIZER_LAST_EN
      if (m_idx == 4 || l) begin
         e.l = l;
`else
      if (m_idx == 4) begin
         e.l = 1'b0;
`endif
         e.d = m_word;
         e.c = 3'(m_idx);
         sb.push_back(e);
         model_clear();
      end
   endtask

   // Output side of the scoreboard: every completed handshake pops one expected word.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_n_i && !flush_i && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            check("unexpected_word", 64'(data_o), 64'hDEAD);
         end else begin
            e = sb.pop_front();
            check("word_data", 64'(data_o), 64'(e.d));
            check("word_cnt", 64'(cnt_o), 64'(e.c));
            check("word_last", 64'(last_o), 64'(e.l));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_data", 64'(data_o), 64'd0);
      check("rst_cnt", 64'(cnt_o), 64'd0);
      check("rst_last", 64'(last_o), 64'd0);
      check("rst_ready", 64'(ready_o), 64'd1);
      #9 rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic word and latency
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      valid_i = 1'b0;
      @(negedge clk_i);
      check("lat_valid", 64'(valid_o), 64'd1);
      check("lat_data", 64'(data_o), 64'h44332211);
      check("lat_cnt", 64'(cnt_o), 64'd4);
      @(negedge clk_i);
      check("lat_valid_fall", 64'(valid_o), 64'd0);
      @(posedge clk_i);
      #1;

      // Backpressure
      ready_i = 1'b0;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      valid_i = 1'b1;
      data_i  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("bp_ready", 64'(ready_o), 64'd0);
         check("bp_valid", 64'(valid_o), 64'd1);
         check("bp_data", 64'(data_o), 64'h44332211);
      end
      @(posedge clk_i);
      #1;
      ready_i = 1'b1;
      send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      @(posedge clk_i);
      #1;

      // Full throughput: 8 consecutive beats
      stalls = 0;
      for (int i = 1; i <= 8; i++) send(8'(i), 0);
      valid_i = 1'b0;
      check("thru_stalls", 64'(stalls), 64'd0);
      repeat (2) @(negedge clk_i);
      @(posedge clk_i);
      #1;

`ifdef STREAM_UPSIZER_LAST_EN
      // Early close with last_i
      send(8'hAA, 0); send(8'hBB, 1);
      valid_i = 1'b0;
      last_i  = 1'b0;
      @(negedge clk_i);
      check("last_data", 64'(data_o), 64'h0000BBAA);
      check("last_cnt", 64'(cnt_o), 64'd2);
      check("last_flag", 64'(last_o), 64'd1);
      @(posedge clk_i);
      #1;
      send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 1);
      send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
      valid_i = 1'b0;
      last_i  = 1'b0;
      repeat (2) @(negedge clk_i);
      @(posedge clk_i);
      #1;
`endif

      // Flush of a partial word with valid_i held high
      send(8'h91, 0); send(8'h92, 0);
      flush_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'h93;
      @(negedge clk_i);
      check("flush_ready", 64'(ready_o), 64'd0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      model_clear();
      @(negedge clk_i);
      check("flush_valid", 64'(valid_o), 64'd0);
      check("flush_data", 64'(data_o), 64'd0);
      check("flush_cnt", 64'(cnt_o), 64'd0);
      @(posedge clk_i);
      #1;
      send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      @(posedge clk_i);
      #1;

      // Flush discards a pending word even with ready_i high
      ready_i = 1'b0;
      send(8'hF1, 0); send(8'hF2, 0); send(8'hF3, 0); send(8'hF4, 0);
      valid_i = 1'b0;
      void'(sb.pop_back());
      ready_i = 1'b1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_pend_valid", 64'(valid_o), 64'd0);
      check("flush_pend_data", 64'(data_o), 64'd0);
      @(posedge clk_i);
      #1;

      // Asynchronous reset mid-word
      send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
      valid_i = 1'b0;
      #1 rst_n_i = 1'b0;
      #1;
      check("arst_valid", 64'(valid_o), 64'd0);
      check("arst_data", 64'(data_o), 64'd0);
      check("arst_cnt", 64'(cnt_o), 64'd0);
      check("arst_ready", 64'(ready_o), 64'd1);
      model_clear();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
      valid_i = 1'b0;
      repeat (3) @(negedge clk_i);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
